// File: rtl/mem_b_arbiter.sv
// Round-robin arbiter sharing memory port B among display, song player and key logger.
// Display reads may burst over consecutive addresses; all port-B outputs are registered.
module mem_b_arbiter #(
    parameter int ADDR_W = 16,
    parameter int DATA_W = 16
) (
    input  logic              clock,
    input  logic              reset,
    input  logic [2:0]        req,
    input  logic [ADDR_W-1:0] addr0,
    input  logic [ADDR_W-1:0] addr1,
    input  logic [ADDR_W-1:0] addr2,
    input  logic              we0,
    input  logic              we1,
    input  logic              we2,
    input  logic [DATA_W-1:0] wdata0,
    input  logic [DATA_W-1:0] wdata1,
    input  logic [DATA_W-1:0] wdata2,
    input  logic [3:0]        burst_len,
    input  logic [DATA_W-1:0] data_b,
    output logic [ADDR_W-1:0] Address_B,
    output logic              we_b,
    output logic [DATA_W-1:0] din_b,
    output logic [2:0]        gnt,
    output logic [2:0]        rvalid,
    output logic [DATA_W-1:0] rdata,
    output logic              busy
);

    typedef enum logic {IDLE, BURST} state_t;

    state_t            state, state_nx;
    logic [1:0]        ptr, ptr_nx, arb_ptr, win;
    logic [3:0]        cnt, cnt_nx;
    logic [2:0]        gnt_nx, elig, cand;
    logic              found, we_nx;
    logic [ADDR_W-1:0] addr_nx;
    logic [DATA_W-1:0] din_nx;

    logic [2:0][ADDR_W-1:0] addr_v;
    logic [2:0]             we_v;
    logic [2:0][DATA_W-1:0] wdata_v;

    assign addr_v  = {addr2, addr1, addr0};
    assign we_v    = {we2, we1, we0};
    assign wdata_v = {wdata2, wdata1, wdata0};

    // A requester shown on gnt this cycle is still holding req; it is not a new request yet.
    assign elig    = req & ~gnt;
    // The cycle showing the last burst beat arbitrates with requester 1 first.
    assign arb_ptr = (state == BURST) ? 2'd1 : ptr;

    always_comb begin
        found = 1'b0;
        win   = 2'd0;
        cand  = 3'd0;
        for (int k = 0; k < 3; k++) begin
            cand = {1'b0, arb_ptr} + 3'(k);
            if (cand > 3'd2) cand = cand - 3'd3;
            if (!found && elig[cand[1:0]]) begin
                found = 1'b1;
                win   = cand[1:0];
            end
        end
    end

    always_comb begin
        state_nx = state;
        ptr_nx   = ptr;
        cnt_nx   = cnt;
        gnt_nx   = 3'b000;
        addr_nx  = Address_B;
        we_nx    = 1'b0;
        din_nx   = din_b;
        if (state == BURST && cnt != 4'd0) begin
            gnt_nx  = 3'b001;
            addr_nx = Address_B + ADDR_W'(1);
            cnt_nx  = cnt - 4'd1;
        end else begin
            if (state == BURST) begin
                state_nx = IDLE;
                ptr_nx   = 2'd1;
            end
            if (found) begin
                gnt_nx  = 3'b001 << win;
                addr_nx = addr_v[win];
                we_nx   = we_v[win];
                din_nx  = wdata_v[win];
                ptr_nx  = (win == 2'd2) ? 2'd0 : win + 2'd1;
                if (win == 2'd0 && !we0 && burst_len != 4'd0) begin
                    state_nx = BURST;
                    cnt_nx   = burst_len;
                end
            end
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state     <= IDLE;
            ptr       <= 2'd0;
            cnt       <= 4'd0;
            gnt       <= 3'b000;
            Address_B <= '0;
            we_b      <= 1'b0;
            din_b     <= '0;
            rvalid    <= 3'b000;
        end else begin
            state     <= state_nx;
            ptr       <= ptr_nx;
            cnt       <= cnt_nx;
            gnt       <= gnt_nx;
            Address_B <= addr_nx;
            we_b      <= we_nx;
            din_b     <= din_nx;
            rvalid    <= we_b ? 3'b000 : gnt;
        end
    end

    // Port-B read data arrives one cycle after the address, aligned with rvalid.
    assign rdata = (rvalid != 3'b000) ? data_b : '0;
    assign busy  = (state == BURST);

endmodule

// File: tb/tb_mem_b_arbiter.sv
// Randomized scoreboard bench for mem_b_arbiter: transaction-level reference model
// predicts grants and read data; an independent monitor pops and compares.
module tb_mem_b_arbiter;
    localparam int AW = 16;
    localparam int DW = 16;

    typedef struct {int id; logic [AW-1:0] addr; logic we; logic [DW-1:0] wd; int cyc;} gexp_t;
    typedef struct {int id; logic [DW-1:0] d; int cyc;} rexp_t;
    typedef struct {logic [AW-1:0] addr; logic we; logic [DW-1:0] wd; logic [3:0] bl;} pst_t;
    typedef struct {logic [2:0] g; logic [AW-1:0] a; logic b;} glog_t;

    logic          clock = 1'b0;
    logic          reset = 1'b1;
    logic [2:0]    req = 3'b000;
    logic [AW-1:0] a_v [3];
    logic          we_v [3];
    logic [DW-1:0] wd_v [3];
    logic [3:0]    bl = 4'd0;
    logic [DW-1:0] data_b = '0;
    logic [AW-1:0] Address_B;
    logic          we_b, busy;
    logic [DW-1:0] din_b, rdata;
    logic [2:0]    gnt, rvalid;

    logic [DW-1:0] mem [0:65535];
    logic [DW-1:0] ref_mem [0:65535];

    gexp_t gq[$];
    rexp_t rq[$];
    pst_t  pq[3][$];
    glog_t glog[$];
    logic [DW-1:0] rlog[$];

    int checks = 0, errors = 0, cyc = 0, activity = 0;
    logic rand_en = 1'b0;
    logic [2:0] rise = 3'b000, glast = 3'b000;

    mem_b_arbiter #(.ADDR_W(AW), .DATA_W(DW)) dut (
        .clock(clock), .reset(reset), .req(req),
        .addr0(a_v[0]), .addr1(a_v[1]), .addr2(a_v[2]),
        .we0(we_v[0]), .we1(we_v[1]), .we2(we_v[2]),
        .wdata0(wd_v[0]), .wdata1(wd_v[1]), .wdata2(wd_v[2]),
        .burst_len(bl), .data_b(data_b), .Address_B(Address_B), .we_b(we_b),
        .din_b(din_b), .gnt(gnt), .rvalid(rvalid), .rdata(rdata), .busy(busy)
    );

    initial forever #5 clock = ~clock;
    always @(posedge clock) cyc <= cyc + 1;

    // Synchronous-read memory on port B.
    always @(posedge clock) begin
        if (we_b) mem[Address_B] <= din_b;
        data_b <= mem[Address_B];
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h want %0h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    task automatic post(input int i, input logic [AW-1:0] a, input logic w, input logic [DW-1:0] d,
                        input logic [3:0] b);
        pst_t p;
        p.addr = a; p.we = w; p.wd = d; p.bl = b;
        pq[i].push_back(p);
    endtask

    task automatic load(input int i);
        pst_t p;
        p = pq[i].pop_front();
        a_v[i] = p.addr; we_v[i] = p.we; wd_v[i] = p.wd;
        if (i == 0) bl = p.bl;
        req[i] = 1'b1;
    endtask

    task automatic rand_load(input int i);
        logic [AW-1:0] a;
        logic [3:0] b;
        a = (i == 0 && $urandom_range(0, 7) == 0) ? AW'(16'hFFF0 + $urandom_range(0, 15))
                                                  : AW'($urandom_range(0, 31));
        b = ($urandom_range(0, 3) == 0) ? 4'($urandom_range(1, 15)) : 4'd0;
        post(i, a, ($urandom_range(0, 2) == 0), DW'($urandom), b);
        load(i);
    endtask

    // Requesters: hold req until a grant is seen, then drop (or re-raise with a queued request).
    initial forever begin
        @(negedge clock);
        rise  = gnt & ~glast;
        glast = gnt;
    end

    initial forever begin
        @(posedge clock);
        #1;
        if (!reset) req = 3'b000;
        else for (int i = 0; i < 3; i++) begin
            if (req[i] && rise[i]) begin
                if (pq[i].size() > 0) load(i);
                else req[i] = 1'b0;
            end else if (!req[i]) begin
                if (pq[i].size() > 0) load(i);
                else if (rand_en && $urandom_range(0, 4) == 0) rand_load(i);
            end
        end
    end

    // Reference model: one grant per cycle, round-robin over requesters not already granted,
    // display read bursts occupy the port for burst_len extra beats, then requester 1 leads.
    int m_cur = -1, m_rr = 0, m_left = 0, w;
    logic [AW-1:0] m_baddr;

    task automatic expect_grant(input int id, input logic [AW-1:0] a, input logic wr, input logic [DW-1:0] d);
        gexp_t g;
        rexp_t r;
        g.id = id; g.addr = a; g.we = wr; g.wd = d; g.cyc = cyc + 1;
        gq.push_back(g);
        if (wr) ref_mem[a] = d;
        else begin
            r.id = id; r.d = ref_mem[a]; r.cyc = cyc + 2;
            rq.push_back(r);
        end
    endtask

    initial forever begin
        @(negedge clock);
        if (!reset) begin
            m_cur = -1; m_rr = 0; m_left = 0;
            gq.delete(); rq.delete();
        end else begin
            w = -1;
            if (m_left > 0) begin
                m_baddr = m_baddr + AW'(1);
                w = 0;
                m_left--;
                if (m_left == 0) m_rr = 1;
                expect_grant(0, m_baddr, 1'b0, '0);
            end else begin
                for (int k = 0; k < 3; k++)
                    if (w < 0 && req[(m_rr + k) % 3] && m_cur != (m_rr + k) % 3) w = (m_rr + k) % 3;
                if (w >= 0) begin
                    expect_grant(w, a_v[w], we_v[w], wd_v[w]);
                    m_rr = (w + 1) % 3;
                    if (w == 0 && !we_v[0] && bl != 4'd0) begin
                        m_left  = int'(bl);
                        m_baddr = a_v[0];
                    end
                end
            end
            m_cur = w;
        end
    end

    // Monitor: pops expectations stamped for this cycle; otherwise the port must be quiet.
    logic [AW-1:0] exp_addr = '0;
    initial forever begin
        gexp_t g;
        rexp_t r;
        @(negedge clock);
        if (!reset) exp_addr = '0;
        else begin
            if (gq.size() > 0 && gq[0].cyc == cyc) begin
                g = gq.pop_front();
                chk("gnt", 32'(gnt), 32'(1) << g.id);
                chk("Address_B", 32'(Address_B), 32'(g.addr));
                chk("we_b", 32'(we_b), 32'(g.we));
                if (g.we) chk("din_b", 32'(din_b), 32'(g.wd));
                exp_addr = g.addr;
            end else begin
                chk("idle_gnt", 32'(gnt), 32'd0);
                chk("idle_we_b", 32'(we_b), 32'd0);
                chk("idle_addr_hold", 32'(Address_B), 32'(exp_addr));
            end
            if (rq.size() > 0 && rq[0].cyc == cyc) begin
                r = rq.pop_front();
                chk("rvalid", 32'(rvalid), 32'(1) << r.id);
                chk("rdata", 32'(rdata), 32'(r.d));
            end else chk("idle_rvalid", 32'(rvalid), 32'd0);
            if (gnt != 3'b000) glog.push_back('{gnt, Address_B, busy});
            if (rvalid != 3'b000) rlog.push_back(rdata);
            if (gnt != 3'b000 || rvalid != 3'b000) activity++;
        end
    end

    task automatic wait_idle(input string nm);
        int n;
        n = 0;
        while ((req != 3'b000 || busy || gq.size() != 0 || rq.size() != 0 ||
                pq[0].size() + pq[1].size() + pq[2].size() != 0) && n < 400) begin
            @(negedge clock);
            n++;
        end
        @(negedge clock);
        chk(nm, 32'(n < 400), 32'd1);
    endtask

    logic [AW-1:0] wrap_a [4];
    logic [2:0]    rr_g [4];
    logic [DW-1:0] rr_d [4];

    initial begin
        for (int i = 0; i < 65536; i++) begin
            mem[i]     = DW'(i) ^ 16'h5A5A;
            ref_mem[i] = DW'(i) ^ 16'h5A5A;
        end
        for (int i = 0; i < 3; i++) begin a_v[i] = '0; we_v[i] = 1'b0; wd_v[i] = '0; end
        wrap_a = '{16'hFFFE, 16'hFFFF, 16'h0000, 16'h0001};
        rr_g   = '{3'b001, 3'b010, 3'b100, 3'b001};
        rr_d   = '{16'h5A5B, 16'h5A58, 16'h5A59, 16'h5A5F};

        #2 reset = 1'b0;
        #1;
        chk("rst_gnt", 32'(gnt), 0);   chk("rst_rvalid", 32'(rvalid), 0);
        chk("rst_we_b", 32'(we_b), 0); chk("rst_addr", 32'(Address_B), 0);
        chk("rst_din", 32'(din_b), 0); chk("rst_rdata", 32'(rdata), 0);
        chk("rst_busy", 32'(busy), 0);
        repeat (3) @(posedge clock);
        #3 reset = 1'b1;
        @(negedge clock);

        glog.delete(); rlog.delete();
        post(0, 16'h0010, 1'b0, '0, 4'd0);
        wait_idle("single_read_done");
        chk("single_gnt_cnt", 32'(glog.size()), 1);
        if (glog.size() > 0) chk("single_addr", 32'(glog[0].a), 32'h0010);
        chk("single_rv_cnt", 32'(rlog.size()), 1);
        if (rlog.size() > 0) chk("single_rdata", 32'(rlog[0]), 32'h5A4A);

        rlog.delete();
        post(2, 16'h0004, 1'b1, 16'h00E9, 4'd0);
        wait_idle("write_done");
        chk("write_no_rvalid", 32'(rlog.size()), 0);
        post(2, 16'h0004, 1'b0, '0, 4'd0);
        wait_idle("readback_done");
        chk("readback_cnt", 32'(rlog.size()), 1);
        if (rlog.size() > 0) chk("readback_data", 32'(rlog[0]), 32'h00E9);

        glog.delete(); rlog.delete();
        post(0, 16'h0001, 1'b0, '0, 4'd0); post(1, 16'h0002, 1'b0, '0, 4'd0);
        post(2, 16'h0003, 1'b0, '0, 4'd0); post(0, 16'h0005, 1'b0, '0, 4'd0);
        wait_idle("rr_done");
        chk("rr_gnt_cnt", 32'(glog.size()), 4);
        chk("rr_rv_cnt", 32'(rlog.size()), 4);
        for (int k = 0; k < 4; k++) begin
            if (k < glog.size()) chk("rr_order", 32'(glog[k].g), 32'(rr_g[k]));
            if (k < rlog.size()) chk("rr_rdata_order", 32'(rlog[k]), 32'(rr_d[k]));
        end

        glog.delete();
        post(0, 16'hFFFE, 1'b0, '0, 4'd3);
        @(negedge clock);
        post(1, 16'h0020, 1'b0, '0, 4'd0);
        wait_idle("wrap_done");
        chk("wrap_gnt_cnt", 32'(glog.size()), 5);
        for (int k = 0; k < 4; k++) if (k < glog.size()) begin
            chk("wrap_gnt", 32'(glog[k].g), 32'b001);
            chk("wrap_addr", 32'(glog[k].a), 32'(wrap_a[k]));
            chk("wrap_busy", 32'(glog[k].b), 32'd1);
        end
        if (glog.size() > 4) chk("wrap_next_gnt", 32'(glog[4].g), 32'b010);

        begin
            int n;
            n = 0;
            post(0, 16'h0100, 1'b0, '0, 4'd15);
            while (!gnt[0] && n < 20) begin @(negedge clock); n++; end
            chk("burst_started", 32'(gnt[0]), 32'd1);
            @(negedge clock);
            @(posedge clock);
            #3 reset = 1'b0;
            #1;
            chk("abort_gnt", 32'(gnt), 0);   chk("abort_rvalid", 32'(rvalid), 0);
            chk("abort_we_b", 32'(we_b), 0); chk("abort_addr", 32'(Address_B), 0);
            chk("abort_din", 32'(din_b), 0); chk("abort_rdata", 32'(rdata), 0);
            chk("abort_busy", 32'(busy), 0);
            repeat (2) @(posedge clock);
            #3 reset = 1'b1;
            activity = 0;
            repeat (20) @(negedge clock);
            chk("quiet_after_reset", 32'(activity), 0);
        end

        rand_en = 1'b1;
        repeat (3000) @(negedge clock);
        rand_en = 1'b0;
        wait_idle("drain_done");
        chk("queues_empty", 32'(gq.size() + rq.size()), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end
endmodule
